// File: rtl/alu_issue_if.sv
// Handshake bundle between fetch, the issue stage, the ALU and writeback.
// master = the side driving instructions/writebacks and consuming the slot;
// slave = the issue stage itself.
interface alu_issue_if #(parameter int DATA_W = 16);
  logic              in_valid;
  logic [15:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_A;
  logic [DATA_W-1:0] out_B;
  logic [1:0]        out_ALUop;
  logic [2:0]        out_rd;
  logic              wb_en;
  logic [2:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              illegal_op;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_A, out_B, out_ALUop, out_rd, illegal_op
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_A, out_B, out_ALUop, out_rd, illegal_op
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the 16-bit ALU: decodes the opcode, reads operands
// from an 8x16 register file (with writeback bypass), tracks in-flight
// destinations in a scoreboard and holds one ID/EX slot.
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input logic       clk,
  input logic       reset,
  alu_issue_if.slave bus
);

  logic [NREGS-1:0][DATA_W-1:0] rf;
  logic [NREGS-1:0]             pending;

  logic              slot_vld;
  logic [DATA_W-1:0] slot_a, slot_b;
  logic [1:0]        slot_op;
  logic [2:0]        slot_rd;
  logic              ill_q;

  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;
  logic       legal, rform;
  logic [1:0] aluop;
  logic [DATA_W-1:0] opa, opb, imm_sx;
  logic [NREGS-1:0]  clr_v, set_v;
  logic       hazard, slot_free, accept;

  assign op     = bus.in_instr[15:12];
  assign rd     = bus.in_instr[11:9];
  assign rs1    = bus.in_instr[8:6];
  assign rs2    = bus.in_instr[5:3];
  assign imm_sx = {{(DATA_W-6){bus.in_instr[5]}}, bus.in_instr[5:0]};

  // Opcode decode: bit 2 selects the immediate form, bits 1:0 are the ALU op.
  always_comb begin
    legal = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101, 4'b0110: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    rform = ~op[2];
    aluop = op[1:0];
  end

  // Operand read; a same-cycle writeback to a nonzero source is forwarded.
  always_comb begin
    opa = rf[rs1];
    if (bus.wb_en && bus.wb_rd == rs1 && rs1 != 3'd0) opa = bus.wb_data;
    opb = imm_sx;
    if (rform) begin
      opb = rf[rs2];
      if (bus.wb_en && bus.wb_rd == rs2 && rs2 != 3'd0) opb = bus.wb_data;
    end
  end

  // Scoreboard clear/set vectors for this cycle.
  always_comb begin
    clr_v = '0;
    set_v = '0;
    if (bus.wb_en) clr_v[bus.wb_rd] = 1'b1;
    if (accept && legal && rd != 3'd0) set_v[rd] = 1'b1;
  end

  // A register being cleared this cycle no longer blocks; illegal ops never stall.
  assign hazard = legal &&
                  ((pending[rs1] && !clr_v[rs1]) ||
                   (rform && pending[rs2] && !clr_v[rs2]) ||
                   (pending[rd] && !clr_v[rd]));

  assign slot_free    = !slot_vld || bus.out_ready;
  assign bus.in_ready = !reset && !hazard && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // ID/EX slot: load on a legal accept, otherwise drain when consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld <= 1'b0;
      slot_a   <= '0;
      slot_b   <= '0;
      slot_op  <= 2'b00;
      slot_rd  <= 3'd0;
      ill_q    <= 1'b0;
    end else begin
      ill_q <= accept && !legal;
      if (accept && legal) begin
        slot_vld <= 1'b1;
        slot_a   <= opa;
        slot_b   <= opb;
        slot_op  <= aluop;
        slot_rd  <= rd;
      end else if (bus.out_ready) begin
        slot_vld <= 1'b0;
      end
    end
  end

  // Scoreboard update: set wins over a same-cycle clear; R0 never pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= ((pending & ~clr_v) | set_v) & ~{{(NREGS-1){1'b0}}, 1'b1};
  end

  // Register file write port; R0 is hardwired to zero by never writing it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rf <= '0;
    else if (bus.wb_en && bus.wb_rd != 3'd0) rf[bus.wb_rd] <= bus.wb_data;
  end

  assign bus.out_valid  = slot_vld;
  assign bus.out_A      = slot_a;
  assign bus.out_B      = slot_b;
  assign bus.out_ALUop  = slot_op;
  assign bus.out_rd     = slot_rd;
  assign bus.illegal_op = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: inputs change 1ns after a rising edge,
// combinational in_ready is checked 1ns later, registered outputs 1ns after
// the edge that loads them.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  alu_issue_if #(.DATA_W(16)) bus ();

  alu_issue_stage #(.DATA_W(16), .NREGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] o, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2);
    return {o, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] o, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [5:0] imm);
    return {o, d, s1, imm};
  endfunction

  task automatic chk_slot(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] o, input logic [2:0] d);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".A"},     {16'd0, bus.out_A},     {16'd0, a});
    chk({tag, ".B"},     {16'd0, bus.out_B},     {16'd0, b});
    chk({tag, ".op"},    {30'd0, bus.out_ALUop}, {30'd0, o});
    chk({tag, ".rd"},    {29'd0, bus.out_rd},    {29'd0, d});
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    #3;
    chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.out_A",     {16'd0, bus.out_A},     32'd0);
    chk("rst.out_rd",    {29'd0, bus.out_rd},    32'd0);
    chk("rst.illegal",   {31'd0, bus.illegal_op}, 32'd0);
    step(); reset = 1'b0;

    // R1 = 3, R2 = 2 through writeback
    bus.wb_en = 1'b1; bus.wb_rd = 3'd1; bus.wb_data = 16'd3; step();
    bus.wb_rd = 3'd2; bus.wb_data = 16'd2; step();
    bus.wb_en = 1'b0;

    // ADD r3 = r1 + r2
    bus.in_valid = 1'b1; bus.in_instr = enc_r(4'b0001, 3'd3, 3'd1, 3'd2); #1;
    chk("add.ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_slot("add", 16'd3, 16'd2, 2'b01, 3'd3);

    // RAW on r3: AND r5 = r3 & r0 stalls until writeback of r3
    bus.in_instr = enc_r(4'b0000, 3'd5, 3'd3, 3'd0); #1;
    chk("raw.stall0", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("raw.drained", {31'd0, bus.out_valid}, 32'd0);
    chk("raw.stall1",  {31'd0, bus.in_ready},  32'd0);
    step();
    chk("raw.stall2",  {31'd0, bus.in_ready},  32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'h00F0; #1;
    chk("raw.release", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_slot("raw", 16'h00F0, 16'h0000, 2'b00, 3'd5);
    bus.in_valid = 1'b0;

    // R1 = 30, then SUBI r4 = r1 - sext(3E)
    bus.wb_rd = 3'd1; bus.wb_data = 16'd30; step();
    bus.wb_en = 1'b0;
    chk("drain.valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = enc_i(4'b0110, 3'd4, 3'd1, 6'h3E); #1;
    chk("subi.ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_slot("subi", 16'd30, 16'hFFFE, 2'b10, 3'd4);

    // Backpressure: slot holds for 3 cycles, then consume + accept together
    bus.out_ready = 1'b0; bus.in_instr = enc_r(4'b0001, 3'd6, 3'd1, 3'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      chk_slot("bp.hold", 16'd30, 16'hFFFE, 2'b10, 3'd4);
    end
    bus.out_ready = 1'b1; #1;
    chk("bp.ready_rel", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_slot("bp.reload", 16'd30, 16'd2, 2'b01, 3'd6);

    // Illegal F000: consumed, one-cycle pulse, no issue
    bus.in_instr = 16'hF000; #1;
    chk("ill.ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("ill.pulse", {31'd0, bus.illegal_op}, 32'd1);
    chk("ill.novld", {31'd0, bus.out_valid},  32'd0);
    // Illegal op naming pending r6 as source and r7 as dest: no stall, no scoreboard change
    bus.in_instr = {4'b0011, 3'd7, 3'd6, 6'd0}; #1;
    chk("ill.nohaz", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("ill.pulse2", {31'd0, bus.illegal_op}, 32'd1);
    bus.in_valid = 1'b0; step();
    chk("ill.pulse_end", {31'd0, bus.illegal_op}, 32'd0);
    chk("ill.novld2",    {31'd0, bus.out_valid},  32'd0);
    bus.in_valid = 1'b1; bus.in_instr = enc_r(4'b0001, 3'd1, 3'd7, 3'd0); #1;
    chk("ill.r7_free", {31'd0, bus.in_ready}, 32'd0 + 32'd1);
    bus.in_instr = enc_r(4'b0001, 3'd1, 3'd6, 3'd0); #1;
    chk("ill.r6_kept", {31'd0, bus.in_ready}, 32'd0);

    // Reset mid-stall: ADD r3 held in slot, AND on r3 stalled
    bus.out_ready = 1'b0; bus.in_instr = enc_r(4'b0001, 3'd3, 3'd1, 3'd2); step();
    chk("mid.loaded", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1; bus.in_instr = enc_r(4'b0000, 3'd7, 3'd3, 3'd0); #1;
    chk("mid.stall", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1; #1;
    chk("mid.rst_vld",   {31'd0, bus.out_valid}, 32'd0);
    chk("mid.rst_ready", {31'd0, bus.in_ready},  32'd0);
    reset = 1'b0; #1;
    chk("mid.no_stall", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_slot("mid.issue", 16'd0, 16'd0, 2'b00, 3'd7);

    // Writes to R0 are dropped and never bypassed
    bus.wb_en = 1'b1; bus.wb_rd = 3'd0; bus.wb_data = 16'h1234;
    bus.in_instr = enc_i(4'b0101, 3'd1, 3'd0, 6'h01); step();
    chk_slot("r0.bypass", 16'd0, 16'd1, 2'b01, 3'd1);
    bus.wb_en = 1'b0; bus.in_instr = enc_r(4'b0001, 3'd2, 3'd0, 3'd0); step();
    chk_slot("r0.read", 16'd0, 16'd0, 2'b01, 3'd2);
    bus.in_valid = 1'b0; step();
    chk("end.drain", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
